// File: rtl/vsa_mem.sv
// vsa_mem: instruction and data memory for a small processor.
// The instruction memory is filled through a load stream before the
// program runs. While the program runs, the processor fetches instructions
// and reads and writes data. Stores made while running are counted, and the
// count saturates at its maximum value.
//
// Load handshake (ld_valid / ld_ready):
//   ld_ready is high only in LOAD. A word transfers on the rising clock edge
//   when ld_valid and ld_ready are both high. ld_data and ld_last are only
//   meaningful while ld_valid is high. ld_valid has no effect when ld_ready
//   is low, and the source may hold ld_valid low for any number of cycles.
module vsa_mem #(
    parameter logic [11:0] NOP   = 12'h800,
    parameter int          CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       PC,
    output logic [11:0]      instruction,
    input  logic [4:0]       ALUOutput,
    output logic [4:0]       datain,
    input  logic [4:0]       dataout,
    input  logic             wr,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [11:0]      ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             running,
    output logic [CNT_W-1:0] store_count,
    output logic [1:0]       debugState,
    output logic [4:0]       debugPtr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  ptr;
    logic [11:0] imem [32];
    logic [4:0]  dmem [32];

    logic loadAccept;
    logic storeAccept;
    logic loadDone;

    // A reload request in RUN takes priority over a store in the same cycle.
    assign loadAccept  = (state == LOAD) && ld_valid;
    assign storeAccept = (state == RUN) && wr && !ld_start;
    assign loadDone    = ld_last || (ptr == 5'd31);

    assign ld_ready    = (state == LOAD);
    assign running     = (state == RUN);
    assign instruction = (state == RUN) ? imem[PC] : NOP;
    assign datain      = dmem[ALUOutput];
    assign debugState  = state;
    assign debugPtr    = ptr;

    // Control FSM: load pointer, state transitions and the saturating store counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 5'd0;
            store_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state <= LOAD;
                        ptr   <= 5'd0;
                    end
                end
                LOAD: begin
                    // The pointer stops at the last entry. Reaching it ends the load.
                    if (loadAccept) begin
                        if (ptr != 5'd31) begin
                            ptr <= ptr + 5'd1;
                        end
                        if (loadDone) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (ld_start) begin
                        state <= LOAD;
                        ptr   <= 5'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= 5'd0;
                end
            endcase

            if (storeAccept && (store_count != {CNT_W{1'b1}})) begin
                store_count <= store_count + CNT_W'(1);
            end
        end
    end

    // Memory arrays: reset clears both, load writes imem, stores in RUN write dmem.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                imem[i] <= NOP;
                dmem[i] <= 5'd0;
            end
        end else begin
            if (loadAccept) begin
                imem[ptr] <= ld_data;
            end
            if (storeAccept) begin
                dmem[ALUOutput] <= dataout;
            end
        end
    end

endmodule

// File: tb/tb_vsa_mem.sv
// Directed testbench for vsa_mem. Inputs change 1 ns after the rising clock
// edge. Outputs are sampled before the next rising edge.
module tb_vsa_mem;

    logic        clock;
    logic        reset;
    logic [4:0]  PC;
    logic [11:0] instruction;
    logic [4:0]  ALUOutput;
    logic [4:0]  datain;
    logic [4:0]  dataout;
    logic        wr;
    logic        ld_start;
    logic        ld_valid;
    logic [11:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        running;
    logic [7:0]  store_count;
    logic [1:0]  debugState;
    logic [4:0]  debugPtr;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    logic [11:0] expWord;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    vsa_mem dut (
        .clock(clock),
        .reset(reset),
        .PC(PC),
        .instruction(instruction),
        .ALUOutput(ALUOutput),
        .datain(datain),
        .dataout(dataout),
        .wr(wr),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .ld_ready(ld_ready),
        .running(running),
        .store_count(store_count),
        .debugState(debugState),
        .debugPtr(debugPtr)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1; PC = 5'd0; ALUOutput = 5'd0; dataout = 5'd0; wr = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 12'h000; ld_last = 1'b0;
        tick();
        tick();
        check("rst_running", 32'(running), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_instr", 32'(instruction), 32'h800);
        check("rst_count", 32'(store_count), 32'd0);
        check("rst_state", 32'(debugState), 32'(S_IDLE));
        check("rst_datain", 32'(datain), 32'd0);
        reset = 1'b0;

        // Store in IDLE is ignored
        ALUOutput = 5'd9; dataout = 5'd7; wr = 1'b1; ld_valid = 1'b1;
        tick();
        wr = 1'b0; ld_valid = 1'b0;
        check("idle_wr_count", 32'(store_count), 32'd0);
        check("idle_wr_dmem", 32'(datain), 32'd0);
        check("idle_state", 32'(debugState), 32'(S_IDLE));

        // Enter LOAD. Stores and idle stalls have no effect.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("load_ld_ready", 32'(ld_ready), 32'd1);
        check("load_running", 32'(running), 32'd0);
        check("load_instr", 32'(instruction), 32'h800);
        wr = 1'b1; dataout = 5'd7;
        for (int i = 0; i < 5; i++) tick();
        wr = 1'b0;
        check("stall_ptr", 32'(debugPtr), 32'd0);
        check("stall_state", 32'(debugState), 32'(S_LOAD));
        check("load_wr_count", 32'(store_count), 32'd0);
        check("load_wr_dmem", 32'(datain), 32'd0);

        // Two-word program
        ld_valid = 1'b1; ld_data = 12'h601;
        tick();
        check("w1_ptr", 32'(debugPtr), 32'd1);
        check("w1_state", 32'(debugState), 32'(S_LOAD));
        ld_data = 12'h8A3; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("w2_running", 32'(running), 32'd1);
        check("w2_ld_ready", 32'(ld_ready), 32'd0);
        PC = 5'd0; #1 check("pc0", 32'(instruction), 32'h601);
        PC = 5'd1; #1 check("pc1", 32'(instruction), 32'h8A3);
        PC = 5'd2; #1 check("pc2", 32'(instruction), 32'h800);

        // Store, then read old data in the same cycle and new data after the edge
        ALUOutput = 5'd9; dataout = 5'd21; wr = 1'b1;
        #1 check("st_same_cycle", 32'(datain), 32'd0);
        tick();
        wr = 1'b0;
        check("st_next_cycle", 32'(datain), 32'd21);
        check("st_count1", 32'(store_count), 32'd1);

        // 299 more stores to address 10. The count saturates at 255.
        ALUOutput = 5'd10; wr = 1'b1;
        for (int i = 0; i < 299; i++) begin
            dataout = 5'(i);
            tick();
        end
        wr = 1'b0;
        check("sat_count", 32'(store_count), 32'd255);
        check("sat_dmem10", 32'(datain), 32'd10);

        // Reload with a store in the same cycle. The store is dropped.
        ld_start = 1'b1; wr = 1'b1; dataout = 5'd31;
        tick();
        ld_start = 1'b0; wr = 1'b0;
        check("reload_running", 32'(running), 32'd0);
        check("reload_ld_ready", 32'(ld_ready), 32'd1);
        check("reload_ptr", 32'(debugPtr), 32'd0);
        check("reload_wr_dropped", 32'(datain), 32'd10);

        // 32 words without ld_last
        ld_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ld_data = 12'h100 + 12'(i * 7);
            exp_q.push_back(ld_data);
            if (i == 31) check("w31_before_state", 32'(debugState), 32'(S_LOAD));
            tick();
        end
        ld_valid = 1'b0;
        check("full_state", 32'(debugState), 32'(S_RUN));
        check("full_ptr_nowrap", 32'(debugPtr), 32'd31);
        for (int i = 0; i < 32; i++) begin
            PC = 5'(i);
            expWord = exp_q.pop_front();
            #1 check($sformatf("full_pc%0d", i), 32'(instruction), 32'(expWord));
        end

        // Reset during LOAD after 3 accepted words
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data = 12'h0F0 + 12'(i);
            tick();
        end
        check("abort_ptr3", 32'(debugPtr), 32'd3);
        reset = 1'b1; ld_last = 1'b1;
        tick();
        reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        check("abort_state", 32'(debugState), 32'(S_IDLE));
        check("abort_ld_ready", 32'(ld_ready), 32'd0);
        check("abort_running", 32'(running), 32'd0);
        check("abort_count", 32'(store_count), 32'd0);
        check("abort_dmem10", 32'(datain), 32'd0);
        for (int i = 0; i < 32; i++) begin
            PC = 5'(i);
            #1 check($sformatf("abort_pc%0d", i), 32'(instruction), 32'h800);
        end

        // A one-word load shows that the aborted words were cleared
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 12'hABC; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("after_abort_running", 32'(running), 32'd1);
        PC = 5'd0; #1 check("after_abort_pc0", 32'(instruction), 32'hABC);
        PC = 5'd1; #1 check("after_abort_pc1", 32'(instruction), 32'h800);
        PC = 5'd2; #1 check("after_abort_pc2", 32'(instruction), 32'h800);
        PC = 5'd31; #1 check("after_abort_pc31", 32'(instruction), 32'h800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
